// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
// Optional op_count response counter: define LOGIC_UNIT_ARBITER_STATS_EN.

module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2:0]               rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    output logic [15:0]              op_count,
`endif
    output logic                     rsp_err
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             grant_found;
    logic [PW-1:0]    grant_idx;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] lu_result;
    logic             lu_err;

    logic [2:0]       op_arr [NUM_REQ];
    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[3*g +: 3];
        assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
        assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
    end

    logic_unit_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .found (grant_found),
        .idx   (grant_idx)
    );

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (lu_result),
        .err    (lu_err)
    );

    assign accept    = (state_q == IDLE) && grant_found;
    assign handshake = (state_q == RESP) && rsp_ready;
    assign rsp_id    = 3'(id_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // Operands are captured at grant so requesters may change their inputs afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_arr[grant_idx];
                a_q  <= a_arr[grant_idx];
                b_q  <= b_arr[grant_idx];
                id_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data <= lu_result;
                rsp_err  <= lu_err;
            end
            if (handshake) begin
                ptr <= (id_q == PW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

`ifdef LOGIC_UNIT_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

module logic_unit_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    // First valid requester at or after ptr, wrapping at N-1.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

module logic_unit_core #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (op)
            3'd0: result = a & b;
            3'd1: result = a | b;
            3'd2: result = ~a;
            3'd3: result = ~(a & b);
            3'd4: result = ~(a | b);
            3'd5: result = a ^ b;
            3'd6: result = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end

endmodule
